dmem_port_arbiter: RTL
======================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter: AWIDTH, default 14, word-address width of the attached RAM.
REQ-002 SHALL have parameter: DWIDTH, default 32, data width, fixed at 32.
REQ-003 SHALL have port: clk  input  1  single clock, rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports per requester m0 (CPU LSU) and m1 (loader/DMA): mX_valid in 1; mX_ready out 1; mX_addr in 32 (byte address); mX_wen in 1; mX_funct3 in 3 (RV32I load/store size code); mX_wdata in 32.
REQ-006 SHALL have response ports per requester: mX_rvalid out 1; mX_rdata out 32; mX_err out 1.
REQ-007 SHALL have RAM-side ports: ram_addr out AWIDTH; ram_d out 32; ram_wen out 1; ram_wbe out 4; ram_q in 32, registered RAM read data.

Function
REQ-008 SHALL accept at most one request per cycle; a request is accepted on a rising edge where mX_valid && mX_ready.
REQ-009 SHALL drive mX_ready combinationally: only m0 valid -> m0_ready=1; only m1 valid -> m1_ready=1; both valid -> grant the requester not granted last (round-robin); never both high.
REQ-010 SHALL update the round-robin pointer only on acceptance; maximum wait for a valid requester is one cycle.
REQ-011 SHALL present ram_addr = granted addr[AWIDTH+1:2] combinationally in the accept cycle.
REQ-012 SHALL form the store byte-enable as: SB (000) -> wbe = 1<<addr[1:0], byte replicated x4; SH (001) -> addr[1]=0: 0011, else 1100, halfword replicated x2; SW (010) -> 1111, data unmodified.
REQ-013 SHALL assert ram_wen only on an accepted, legal, aligned store.
REQ-014 SHALL flag illegal: store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}; SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0.
REQ-015 SHALL, for illegal requests, keep ram_wen=0, still accept, and respond with err=1 and rdata=0.
REQ-016 SHALL pulse mX_rvalid for exactly one cycle, in the cycle after acceptance (latency 1), for every accepted load or store, to the accepting requester only.
REQ-017 SHALL register the owner, funct3, addr[1:0], wen and err of the accepted request for the response cycle.
REQ-018 SHALL format load rdata combinationally from ram_q and the registered fields: LB/LBU select byte addr[1:0] with sign/zero extension; LH/LHU select half addr[1] with sign/zero extension; LW returns the whole word.
REQ-019 SHALL drive rdata=0 on store acknowledges; rdata/err SHALL be 0 whenever rvalid=0.
REQ-020 SHALL support back-to-back accepts; a load accepted the cycle after a store to the same word SHALL return the newly written bytes.
REQ-021 SHALL keep ram_wen=0, ram_wbe=0 and both readys low when no request is accepted.
REQ-022 SHALL require requesters to hold their inputs stable while valid && !ready; the arbiter does not sample unaccepted requests.

Reset
REQ-023 SHALL, while rst=1, drive m0_ready=m1_ready=0, ram_wen=0, ram_wbe=0, and clear both rvalid and err outputs to 0.
REQ-024 SHALL reset the round-robin pointer so that m0 wins the first contention after reset.
REQ-025 SHALL drop a response pending when rst asserts; no rvalid SHALL follow deassertion unless a new accept occurs.

Structure
REQ-026 SHALL take funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW) from the shared CPU package, with no local redefinition.
REQ-027 SHALL place store byte-enable/replication and load extraction/extension in one sub-module, mem_align_unit, which is purely combinational.
REQ-028 SHALL keep arbitration, the response register and the pointer in the top-level module.

Verification
REQ-029 SHALL cover: m0 SW addr 0x10 data 0xDEADBEEF, then m0 LW 0x10 -> ram_wbe=1111; next cycle rvalid with rdata 0xDEADBEEF.
REQ-030 SHALL cover: SB 0x80 to addr 0x13, then LB 0x13 -> wbe=1000, rdata 0xFFFFFF80; then LBU 0x13 -> rdata 0x00000080.
REQ-031 SHALL cover: m0 and m1 both valid for 4 cycles -> grants alternate m0,m1,m0,m1; each rvalid arrives one cycle after its own grant.
REQ-032 SHALL cover: LW addr 0x6, and SH addr 0x5 -> ram_wen=0; next cycle err=1, rdata=0; RAM contents unchanged.
REQ-033 SHALL cover: rst asserted in the cycle after an accepted load -> no rvalid; first contention after reset grants m0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared CPU memory definitions for the data-memory port arbiter.
//   - RV32I load/store funct3 size codes
//   - requester identity and the registered response record
package dmem_port_arbiter_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic {
        OwnerM0,
        OwnerM1
    } owner_e;

    // Fields of an accepted request needed in its response cycle
    typedef struct packed {
        owner_e     owner;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
        logic       wen;
        logic       err;
    } rsp_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side data-memory bus: request handshake plus one-cycle response.
//   valid/ready  request handshake (accept on valid && ready)
//   addr         byte address
//   wen          1 = store, 0 = load
//   funct3       RV32I size code
//   wdata        store data
//   rvalid       one-cycle response strobe
//   rdata        formatted load data (0 for stores / errors)
//   err          illegal request flag, valid with rvalid
interface dmem_port_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, addr, wen, funct3, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, addr, wen, funct3, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_port_arbiter_mem_align_unit.sv
// Purely combinational alignment unit.
//   Request side: legality check, store byte-enable and lane replication.
//   Response side: load byte/half extraction with sign/zero extension.
// Ports:
//   req_wen_i, req_funct3_i, req_addr_lo_i, req_wdata_i  granted request
//   req_illegal_o                                      size/alignment violation
//   st_wbe_o, st_wdata_o                               RAM byte-enable and data
//   rsp_funct3_i, rsp_addr_lo_i, ram_q_i               registered load fields + RAM data
//   ld_data_o                                          formatted load data
module mem_align_unit
    import dmem_port_arbiter_pkg::*;
(
    input  logic        req_wen_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_illegal_o,
    output logic [3:0]  st_wbe_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  rsp_funct3_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [31:0] ram_q_i,
    output logic [31:0] ld_data_o
);

    always_comb begin
        req_illegal_o = 1'b0;
        if (req_wen_i) begin
            unique case (req_funct3_i)
                FUNCT3_SB: req_illegal_o = 1'b0;
                FUNCT3_SH: req_illegal_o = req_addr_lo_i[0];
                FUNCT3_SW: req_illegal_o = (req_addr_lo_i != 2'b00);
                default:   req_illegal_o = 1'b1;
            endcase
        end else begin
            unique case (req_funct3_i)
                FUNCT3_LB, FUNCT3_LBU: req_illegal_o = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: req_illegal_o = req_addr_lo_i[0];
                FUNCT3_LW:             req_illegal_o = (req_addr_lo_i != 2'b00);
                default:               req_illegal_o = 1'b1;
            endcase
        end
    end

    // Replicate narrow store data to every lane so the byte-enable alone
    // picks the destination bytes.
    always_comb begin
        st_wbe_o   = 4'b0000;
        st_wdata_o = req_wdata_i;
        unique case (req_funct3_i)
            FUNCT3_SB: begin
                st_wbe_o   = 4'b0001 << req_addr_lo_i;
                st_wdata_o = {4{req_wdata_i[7:0]}};
            end
            FUNCT3_SH: begin
                st_wbe_o   = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{req_wdata_i[15:0]}};
            end
            FUNCT3_SW: st_wbe_o = 4'b1111;
            default:   st_wbe_o = 4'b0000;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = ram_q_i[{rsp_addr_lo_i, 3'b000} +: 8];
        ld_half   = rsp_addr_lo_i[1] ? ram_q_i[31:16] : ram_q_i[15:0];
        ld_data_o = 32'h0;
        unique case (rsp_funct3_i)
            FUNCT3_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            FUNCT3_LBU: ld_data_o = {24'h0, ld_byte};
            FUNCT3_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            FUNCT3_LHU: ld_data_o = {16'h0, ld_half};
            FUNCT3_LW:  ld_data_o = ram_q_i;
            default:    ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word RAM with
// registered read data. One request accepted per cycle, response one cycle later.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   m0, m1            requester buses (m0 = CPU LSU, m1 = loader/DMA)
//   ram_addr_o        word address of the granted request
//   ram_d_o           lane-replicated store data
//   ram_wen_o         write strobe (accepted, legal store only)
//   ram_wbe_o         byte enables, zero unless ram_wen_o
//   ram_q_i           registered RAM read data
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned AWIDTH = 14,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_port_arbiter_if.slave m0,
    dmem_port_arbiter_if.slave m1,
    output logic [AWIDTH-1:0] ram_addr_o,
    output logic [DWIDTH-1:0] ram_d_o,
    output logic              ram_wen_o,
    output logic [3:0]        ram_wbe_o,
    input  logic [DWIDTH-1:0] ram_q_i
);

    // Set when m1 should win the next contention
    logic prio_m1_q, prio_m1_d;
    logic rsp_valid_q;
    rsp_t rsp_q, rsp_d;

    logic        grant_m0, grant_m1, accept;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        req_illegal;
    logic [3:0]  st_wbe;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [31:0] rsp_data;
    logic        unused_addr;

    always_comb begin
        grant_m0   = !rst && m0.valid && (!m1.valid || !prio_m1_q);
        grant_m1   = !rst && m1.valid && (!m0.valid || prio_m1_q);
        accept     = grant_m0 || grant_m1;
        req_addr   = grant_m1 ? m1.addr   : m0.addr;
        req_wen    = grant_m1 ? m1.wen    : m0.wen;
        req_funct3 = grant_m1 ? m1.funct3 : m0.funct3;
        req_wdata  = grant_m1 ? m1.wdata  : m0.wdata;
    end

    assign m0.ready    = grant_m0;
    assign m1.ready    = grant_m1;
    assign unused_addr = ^req_addr[31:AWIDTH+2];

    mem_align_unit u_align (
        .req_wen_i     (req_wen),
        .req_funct3_i  (req_funct3),
        .req_addr_lo_i (req_addr[1:0]),
        .req_wdata_i   (req_wdata),
        .req_illegal_o (req_illegal),
        .st_wbe_o      (st_wbe),
        .st_wdata_o    (st_wdata),
        .rsp_funct3_i  (rsp_q.funct3),
        .rsp_addr_lo_i (rsp_q.addr_lo),
        .ram_q_i       (ram_q_i),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        ram_addr_o = req_addr[AWIDTH+1:2];
        ram_d_o    = st_wdata;
        ram_wen_o  = accept && req_wen && !req_illegal;
        ram_wbe_o  = ram_wen_o ? st_wbe : 4'b0000;
    end

    always_comb begin
        prio_m1_d     = accept ? grant_m0 : prio_m1_q;
        rsp_d.owner   = grant_m1 ? OwnerM1 : OwnerM0;
        rsp_d.funct3  = req_funct3;
        rsp_d.addr_lo = req_addr[1:0];
        rsp_d.wen     = req_wen;
        rsp_d.err     = req_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_m1_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            prio_m1_q   <= prio_m1_d;
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_q <= rsp_d;
            end
        end
    end

    // Gating with rst suppresses a response still in flight when reset hits.
    always_comb begin
        rsp_data  = (!rsp_q.wen && !rsp_q.err) ? ld_data : 32'h0;
        m0.rvalid = !rst && rsp_valid_q && (rsp_q.owner == OwnerM0);
        m1.rvalid = !rst && rsp_valid_q && (rsp_q.owner == OwnerM1);
        m0.rdata  = m0.rvalid ? rsp_data : 32'h0;
        m1.rdata  = m1.rvalid ? rsp_data : 32'h0;
        m0.err    = m0.rvalid && rsp_q.err;
        m1.err    = m1.rvalid && rsp_q.err;
    end

endmodule
